acq_window_ctrl: RTL and testbench

- Acquisition window controller, directly downstream of the DSO timebase clock divider.
- Consumes the divided timebase tick, decimates it into single-cycle ADC sample strobes, and generates write addresses for the circular capture RAM.
- Sequences a pre-trigger / post-trigger capture window and reports the trigger position to the readout logic.

---
 rtl/acq_window_ctrl_if.sv | 54 +++++
 rtl/acq_window_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_acq_window_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/acq_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : acq_window_ctrl_if
// Description : Signal bundle between the acquisition window controller and
//               its surroundings (timebase, trigger, readout, capture RAM).
//               master : the side that drives the controls and observes status
//               slave  : the acquisition window controller itself
//               Inputs to controller : tick_in, arm, abort, trig, decim,
//                                      pre_len, total_len (+ auto_to)
//               Outputs from controller : sample_en, wr_addr, trig_addr,
//                                      busy, done (+ auto_fired)
//               Optional macro AUTO_TRIG_EN adds auto_to / auto_fired.
// Revision    : 1.0 - initial release
// ============================================================================
interface acq_window_ctrl_if #(
  parameter int DEC_W  = 16,
  parameter int ADDR_W = 12
);
  logic              tick_in;
  logic              arm;
  logic              abort;
  logic              trig;
  logic [DEC_W-1:0]  decim;
  logic [ADDR_W-1:0] pre_len;
  logic [ADDR_W-1:0] total_len;
  logic              sample_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;
`ifdef AUTO_TRIG_EN
  logic [15:0]       auto_to;
  logic              auto_fired;
`endif

  modport master (
    output tick_in, arm, abort, trig, decim, pre_len, total_len,
`ifdef AUTO_TRIG_EN
    output auto_to,
    input  auto_fired,
`endif
    input  sample_en, wr_addr, trig_addr, busy, done
  );

  modport slave (
    input  tick_in, arm, abort, trig, decim, pre_len, total_len,
`ifdef AUTO_TRIG_EN
    input  auto_to,
    output auto_fired,
`endif
    output sample_en, wr_addr, trig_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/acq_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acq_window_ctrl
// Description : Acquisition window controller. Decimates the divided timebase
//               tick into single-cycle capture-RAM write strobes, generates
//               circular write addresses and sequences a pre-trigger /
//               post-trigger window, reporting the trigger sample address.
// Ports       : clkin   - system clock
//               cnt_clr - asynchronous active-low reset
//               bus     - acq_window_ctrl_if.slave (controls in, status out)
// Options     : AUTO_TRIG_EN - forced trigger after auto_to WAIT_TRIG samples
// Revision    : 1.0 - initial release
// ============================================================================
module acq_window_ctrl #(
  parameter int DEC_W  = 16,
  parameter int ADDR_W = 12
) (
  input  wire logic         clkin,
  input  wire logic         cnt_clr,
  acq_window_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  logic              r_tick_d;
  logic              r_trig_d;
  logic [DEC_W-1:0]  r_dec_cnt;
  logic [DEC_W-1:0]  r_decim;
  logic [ADDR_W-1:0] r_pre_len;
  logic [ADDR_W-1:0] r_post_len;
  logic [ADDR_W-1:0] r_smp_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic              r_sample_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_trig_pend;

  logic              w_busy_st;
  logic              w_tick_ev;
  logic              w_trig_ev;
  logic              w_arm_go;
  logic              w_take;
  logic              w_real_trig;
  logic              w_force;
  logic              w_trig_hit;
  logic              w_pre_last;
  logic              w_post_last;
  logic [ADDR_W-1:0] w_post_len_in;

  assign w_busy_st = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_tick_ev = bus.tick_in & ~r_tick_d;
  assign w_trig_ev = bus.trig & ~r_trig_d;

  // Arm only restarts from a quiescent state, and abort always wins.
  assign w_arm_go  = bus.arm & ~bus.abort & ((r_state == S_IDLE) || (r_state == S_DONE));

  // Sample decision is made in the tick-event cycle; strobe follows one cycle later.
  assign w_take    = w_busy_st & ~bus.abort & w_tick_ev & (r_dec_cnt == r_decim);

  // A trig edge arriving during the strobe cycle still claims that sample.
  assign w_real_trig = r_trig_pend | w_trig_ev;
  assign w_trig_hit  = (r_state == S_WAIT) & r_sample_en & ~bus.abort & (w_real_trig | w_force);
  assign w_pre_last  = (r_state == S_PRE) & r_sample_en & (r_smp_cnt == (r_pre_len - C_ONE));
  assign w_post_last = (r_state == S_POST) & r_sample_en & (r_post_cnt == C_ONE);

  // The trigger sample itself is always captured, so post length never drops below 1.
  assign w_post_len_in = (bus.total_len <= bus.pre_len) ? C_ONE : (bus.total_len - bus.pre_len);

`ifdef AUTO_TRIG_EN
  logic [15:0] r_auto_cnt;
  logic        r_auto_fired;

  assign w_force = (bus.auto_to != 16'd0) && (r_auto_cnt == bus.auto_to);

  always_ff @(posedge clkin or negedge cnt_clr) begin
    if (!cnt_clr) begin
      r_auto_cnt   <= 16'd0;
      r_auto_fired <= 1'b0;
    end else if (w_arm_go) begin
      r_auto_cnt   <= 16'd0;
      r_auto_fired <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && r_sample_en && !w_trig_hit && !bus.abort
          && (r_auto_cnt != 16'hFFFF))
        r_auto_cnt <= r_auto_cnt + 16'd1;
      if (w_trig_hit && !w_real_trig)
        r_auto_fired <= 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // State register
  always_ff @(posedge clkin or negedge cnt_clr) begin
    if (!cnt_clr) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_arm_go) w_state_nxt = (bus.pre_len == '0) ? S_WAIT : S_PRE;
      end
      S_PRE: begin
        if (bus.abort)       w_state_nxt = S_IDLE;
        else if (w_pre_last) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.abort)       w_state_nxt = S_IDLE;
        else if (w_trig_hit) w_state_nxt = (r_post_len == C_ONE) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (bus.abort)        w_state_nxt = S_IDLE;
        else if (w_post_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy      = w_busy_st;
    bus.done      = (r_state == S_DONE);
    bus.sample_en = r_sample_en;
    bus.wr_addr   = r_wr_addr;
    bus.trig_addr = r_trig_addr;
`ifdef AUTO_TRIG_EN
    bus.auto_fired = r_auto_fired;
`endif
  end

  // Datapath
  always_ff @(posedge clkin or negedge cnt_clr) begin
    if (!cnt_clr) begin
      r_tick_d    <= 1'b0;
      r_trig_d    <= 1'b0;
      r_dec_cnt   <= '0;
      r_decim     <= '0;
      r_pre_len   <= '0;
      r_post_len  <= '0;
      r_smp_cnt   <= '0;
      r_post_cnt  <= '0;
      r_sample_en <= 1'b0;
      r_wr_addr   <= '0;
      r_trig_addr <= '0;
      r_trig_pend <= 1'b0;
    end else begin
      r_tick_d    <= bus.tick_in;
      r_trig_d    <= bus.trig;
      r_sample_en <= w_take;

      // Address advances after the strobe that wrote it; wraps naturally.
      if (r_sample_en) r_wr_addr <= r_wr_addr + C_ONE;

      if (w_arm_go) begin
        r_dec_cnt  <= '0;
        r_smp_cnt  <= '0;
        r_decim    <= bus.decim;
        r_pre_len  <= bus.pre_len;
        r_post_len <= w_post_len_in;
      end else begin
        if (w_busy_st && w_tick_ev && !bus.abort)
          r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : (r_dec_cnt + 1'b1);
        if ((r_state == S_PRE) && r_sample_en)
          r_smp_cnt <= r_smp_cnt + C_ONE;
      end

      if (w_arm_go || bus.abort || w_trig_hit)
        r_trig_pend <= 1'b0;
      else if ((r_state == S_WAIT) && w_trig_ev)
        r_trig_pend <= 1'b1;

      if (w_trig_hit) begin
        r_trig_addr <= r_wr_addr;
        r_post_cnt  <= r_post_len - C_ONE;
      end else if ((r_state == S_POST) && r_sample_en && !bus.abort) begin
        r_post_cnt  <= r_post_cnt - C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acq_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_window_ctrl
// Description : Directed self-checking bench for acq_window_ctrl (ADDR_W=4 so
//               address wrap is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_window_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clkin   = 1'b0;
  logic cnt_clr = 1'b0;
  always #5 clkin = ~clkin;

  acq_window_ctrl_if #(.DEC_W(DW), .ADDR_W(AW)) bus ();

  acq_window_ctrl #(.DEC_W(DW), .ADDR_W(AW)) dut (
    .clkin   (clkin),
    .cnt_clr (cnt_clr),
    .bus     (bus)
  );

  int n_total   = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int width_err = 0;
  logic prev_en = 1'b0;
  int q_addr[$];
  int q_cyc[$];
  int edge_cyc[30];

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    if (bus.sample_en) begin
      q_addr.push_back(int'(bus.wr_addr));
      q_cyc.push_back(cyc);
      if (prev_en) width_err++;
    end
    prev_en = bus.sample_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic tick1();
    bus.tick_in = 1'b1; step(2);
    bus.tick_in = 1'b0; step(2);
  endtask

  task automatic pulse_arm();   bus.arm   = 1'b1; step(1); bus.arm   = 1'b0; endtask
  task automatic pulse_abort(); bus.abort = 1'b1; step(1); bus.abort = 1'b0; endtask
  task automatic pulse_trig();  bus.trig  = 1'b1; step(1); bus.trig  = 1'b0; endtask

  task automatic clear_q();
    q_addr.delete();
    q_cyc.delete();
  endtask

  initial begin
    bus.tick_in = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0; bus.trig = 1'b0;
    bus.decim = '0; bus.pre_len = '0; bus.total_len = '0;
`ifdef AUTO_TRIG_EN
    bus.auto_to = 16'd0;
`endif
    step(3);
    chk("rst_sample_en", 32'(bus.sample_en), 32'd0);
    chk("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("rst_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    cnt_clr = 1'b1;
    step(2);

    // Normal window: pre 4, total 10 -> trigger at 7, post samples 7..12
    bus.decim = 0; bus.pre_len = 4; bus.total_len = 10;
    clear_q();
    pulse_arm();
    bus.decim = 3;  // must not affect the running capture
    chk("win_busy_after_arm", 32'(bus.busy), 32'd1);
    repeat (7) tick1();
    chk("win_cnt_before_trig", 32'(q_addr.size()), 32'd7);
    chk("win_still_waiting",   32'(bus.busy),      32'd1);
    pulse_trig();
    repeat (6) tick1();
    chk("win_trig_addr", 32'(bus.trig_addr), 32'd7);
    chk("win_done",      32'(bus.done),      32'd1);
    chk("win_busy_end",  32'(bus.busy),      32'd0);
    chk("win_wr_addr",   32'(bus.wr_addr),   32'd13);
    chk("win_cnt",       32'(q_addr.size()), 32'd13);
    if (q_addr.size() == 13) begin
      chk("win_addr7",  32'(q_addr[7]),  32'd7);
      chk("win_addr12", 32'(q_addr[12]), 32'd12);
    end
    tick1();
    chk("win_no_sample_in_done", 32'(q_addr.size()), 32'd13);

    // Abort in WAIT_TRIG (pre_len 0 enters WAIT_TRIG directly)
    bus.decim = 0; bus.pre_len = 0; bus.total_len = 5;
    clear_q();
    pulse_arm();
    tick1();
    pulse_trig();
    pulse_abort();
    chk("abort_busy",      32'(bus.busy),      32'd0);
    chk("abort_trig_addr", 32'(bus.trig_addr), 32'd7);
    tick1();
    chk("abort_no_sample", 32'(q_addr.size()), 32'd1);
    chk("abort_wr_addr",   32'(bus.wr_addr),   32'd14);

    // arm and abort together from IDLE
    bus.arm = 1'b1; bus.abort = 1'b1; step(1); bus.arm = 1'b0; bus.abort = 1'b0;
    chk("collide_busy", 32'(bus.busy), 32'd0);
    chk("collide_done", 32'(bus.done), 32'd0);
    tick1();
    chk("collide_no_sample", 32'(q_addr.size()), 32'd1);

    // Wrap and clamp: start at 14, pre 2, total 2
    bus.pre_len = 2; bus.total_len = 2;
    clear_q();
    pulse_arm();
    tick1(); tick1();
    chk("wrap_in_wait", 32'(bus.busy), 32'd1);
    pulse_trig();
    tick1();
    chk("wrap_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("wrap_done",      32'(bus.done),      32'd1);
    chk("wrap_wr_addr",   32'(bus.wr_addr),   32'd1);
    chk("wrap_cnt",       32'(q_addr.size()), 32'd3);
    if (q_addr.size() == 3) begin
      chk("wrap_a0", 32'(q_addr[0]), 32'd14);
      chk("wrap_a1", 32'(q_addr[1]), 32'd15);
      chk("wrap_a2", 32'(q_addr[2]), 32'd0);
    end

    // Decimation: decim 2, 30 tick edges, tick toggling every 501 cycles
    bus.decim = 2; bus.pre_len = 15; bus.total_len = 15;
    clear_q();
    width_err = 0;
    pulse_arm();
    for (int i = 0; i < 30; i++) begin
      bus.tick_in = 1'b1; edge_cyc[i] = cyc; step(501);
      bus.tick_in = 1'b0; step(501);
    end
    chk("dec_cnt",   32'(q_cyc.size()), 32'd10);
    chk("dec_width", 32'(width_err),    32'd0);
    for (int j = 0; j < 10; j++)
      if (j < q_cyc.size())
        chk($sformatf("dec_pos%0d", j), 32'(q_cyc[j]), 32'(edge_cyc[3*j+2] + 1));
    pulse_abort();
    chk("dec_abort_busy", 32'(bus.busy), 32'd0);

`ifdef AUTO_TRIG_EN
    // wr_addr is 11 here; 6th WAIT_TRIG sample lands at (11+5) mod 16 = 0
    bus.decim = 0; bus.pre_len = 0; bus.total_len = 3; bus.auto_to = 16'd5;
    clear_q();
    pulse_arm();
    repeat (6) tick1();
    chk("auto_fired",     32'(bus.auto_fired), 32'd1);
    chk("auto_trig_addr", 32'(bus.trig_addr),  32'd0);
    chk("auto_in_post",   32'(bus.busy),       32'd1);
    pulse_abort();
    bus.auto_to = 16'd0;
    pulse_arm();
    repeat (101) tick1();
    chk("auto_off_busy",  32'(bus.busy),       32'd1);
    chk("auto_off_fired", 32'(bus.auto_fired), 32'd0);
    pulse_abort();
`endif

    // Asynchronous reset while a strobe is high during POST
    bus.decim = 0; bus.pre_len = 1; bus.total_len = 10;
    pulse_arm();
    tick1();
    pulse_trig();
    tick1();
    tick1();
    chk("rmid_busy_before", 32'(bus.busy), 32'd1);
    bus.tick_in = 1'b1; step(1);
    chk("rmid_strobe_high", 32'(bus.sample_en), 32'd1);
    #1 cnt_clr = 1'b0;
    #1;
    chk("rmid_sample_en", 32'(bus.sample_en), 32'd0);
    chk("rmid_wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("rmid_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("rmid_busy",      32'(bus.busy),      32'd0);
    chk("rmid_done",      32'(bus.done),      32'd0);
    bus.tick_in = 1'b0;
    step(2);
    cnt_clr = 1'b1;
    clear_q();
    step(2);
    repeat (3) tick1();
    chk("rmid_no_sample", 32'(q_addr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
